condlogic: RTL and testbench

Conditional-execution stage of the multicycle ARM controller, directly downstream of the instruction decoder. It holds the architectural NZCV flags, evaluates the 4-bit condition field against them, and gates the decoder's write-enable strobes into the final PC, register-file and memory write enables. An optional retirement/squash counter pair supports performance bring-up.

---
 rtl/condlogic.sv | 57 +++++
 tb/tb_condlogic.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic.sv
// condlogic: ARM condition evaluation, NZCV flag register and write-enable gating with optional perf counters
module condlogic #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
`ifdef COND_PERF_EN
  ,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);
  logic n, z, c, v;
  logic [7:0] t;
  assign {n, z, c, v} = Flags;
  assign t = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
  assign CondEx = t[Cond[3:1]] ^ Cond[0];
  assign PCWrite = (PCS & CondEx) | NextPC;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  always_ff @(posedge clk) begin
    if (!reset) Flags <= 4'b0000;
    else begin
      if (FlagW[1] & CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & CondEx) Flags[1:0] <= ALUFlags[1:0];
    end
  end
`ifdef COND_PERF_EN
  logic started, sticky, squash;
  assign squash = ~CondEx & (RegW | MemW | PCS | (|FlagW));
  always_ff @(posedge clk) begin
    if (!reset) begin
      started <= 1'b0;
      sticky <= 1'b0;
      InstrCount <= '0;
      SquashCount <= '0;
    end else if (NextPC) begin
      started <= 1'b1;
      sticky <= squash;
      if (started && InstrCount != '1) InstrCount <= InstrCount + 1'b1;
      if (started && sticky && SquashCount != '1) SquashCount <= SquashCount + 1'b1;
    end else sticky <= sticky | squash;
  end
`endif
endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic: randomized and directed checks of condlogic against a behavioural model
module tb_condlogic;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond = 4'hE;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0, NextPC = 1'b0, RegW = 1'b0, MemW = 1'b0;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_PERF_EN
  logic [CW-1:0] InstrCount, SquashCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] mflags = 4'h0;
  bit  mstarted = 0, msticky = 0;
  int  mi = 0, ms = 0;

  always #5 clk = ~clk;

  condlogic #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx)
`ifdef COND_PERF_EN
    , .InstrCount(InstrCount), .SquashCount(SquashCount)
`endif
  );

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    bit ce, sq;
    ce = cond_pass(Cond, mflags);
    sq = !ce && (RegW || MemW || PCS || FlagW != 2'b00);
    if (!reset) begin
      mflags = 4'h0; mstarted = 0; msticky = 0; mi = 0; ms = 0;
    end else begin
      if (FlagW[1] && ce) mflags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ce) mflags[1:0] = ALUFlags[1:0];
      if (NextPC) begin
        if (mstarted) begin
          if (mi < CMAX) mi++;
          if (msticky && ms < CMAX) ms++;
        end
        msticky = sq;
        mstarted = 1;
      end else begin
        msticky = msticky || sq;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Cond = 4'hE; FlagW = 2'b00; ALUFlags = 4'h0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
  endtask

  task automatic set_flags(input logic [3:0] val);
    idle();
    FlagW = 2'b11; ALUFlags = val;
    step();
    FlagW = 2'b00;
  endtask

  task automatic test_reset();
    reset = 0; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
    step();
    n_cmp++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    idle();
    #1;
    n_cmp++; if (PCWrite !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || CondEx !== 1'b1) begin
      n_err++; $display("FAIL reset_outputs got pc=%b rw=%b mw=%b ce=%b exp 0 0 0 1", PCWrite, RegWrite, MemWrite, CondEx); end
    NextPC = 1;
    #1;
    n_cmp++; if (PCWrite !== 1'b1) begin n_err++; $display("FAIL reset_nextpc got=%b exp=1", PCWrite); end
`ifdef COND_PERF_EN
    n_cmp++; if (InstrCount !== '0 || SquashCount !== '0) begin
      n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", InstrCount, SquashCount); end
`endif
    idle();
    reset = 1; FlagW = 2'b11; ALUFlags = 4'hF;
    step();
    n_cmp++; if (Flags !== 4'b1111) begin n_err++; $display("FAIL release_flags got=%b exp=1111", Flags); end
    idle();
  endtask

  task automatic test_cond_table();
    logic [3:0] fv [6] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1001};
    foreach (fv[k]) begin
      set_flags(fv[k]);
      n_cmp++; if (Flags !== fv[k]) begin n_err++; $display("FAIL table_setflags got=%b exp=%b", Flags, fv[k]); end
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); RegW = 1;
        #1;
        n_cmp++; if (RegWrite !== cond_pass(4'(c), fv[k]) || CondEx !== cond_pass(4'(c), fv[k])) begin
          n_err++; $display("FAIL table flags=%b cond=%h got rw=%b ce=%b exp=%b", fv[k], c, RegWrite, CondEx, cond_pass(4'(c), fv[k])); end
      end
      Cond = 4'hF;
      #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL table_nv flags=%b got=%b exp=0", fv[k], RegWrite); end
      idle();
    end
  endtask

  task automatic test_partial_flags();
    set_flags(4'b0000);
    FlagW = 2'b10; ALUFlags = 4'b1111;
    step();
    n_cmp++; if (Flags !== 4'b1100) begin n_err++; $display("FAIL partial_nz got=%b exp=1100", Flags); end
    FlagW = 2'b01; ALUFlags = 4'b0011;
    step();
    n_cmp++; if (Flags !== 4'b1111) begin n_err++; $display("FAIL partial_cv got=%b exp=1111", Flags); end
    idle();
  endtask

  task automatic test_squashed_flag_write();
    set_flags(4'b0100);
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000; MemW = 1; RegW = 1;
    #1;
    n_cmp++; if (CondEx !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_err++; $display("FAIL squash_outputs got ce=%b mw=%b rw=%b exp 0 0 0", CondEx, MemWrite, RegWrite); end
    step();
    n_cmp++; if (Flags !== 4'b0100) begin n_err++; $display("FAIL squash_flags got=%b exp=0100", Flags); end
    idle();
  endtask

  task automatic test_branch_gating();
    set_flags(4'b0000);
    Cond = 4'b0000; PCS = 1; NextPC = 0;
    #1;
    n_cmp++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL branch_notaken got=%b exp=0", PCWrite); end
    NextPC = 1;
    #1;
    n_cmp++; if (PCWrite !== 1'b1) begin n_err++; $display("FAIL branch_nextpc got=%b exp=1", PCWrite); end
    set_flags(4'b0100);
    Cond = 4'b0000; PCS = 1;
    #1;
    n_cmp++; if (PCWrite !== 1'b1) begin n_err++; $display("FAIL branch_taken got=%b exp=1", PCWrite); end
    idle();
  endtask

  task automatic test_random();
    bit ce;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
      PCS = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom);
      NextPC = ($urandom_range(0, 3) == 0);
      #1;
      ce = cond_pass(Cond, mflags);
      n_cmp++; if (CondEx !== ce || PCWrite !== ((PCS && ce) || NextPC) || RegWrite !== (RegW && ce) || MemWrite !== (MemW && ce)) begin
        n_err++; $display("FAIL random_comb i=%0d cond=%h flags=%b got ce=%b pc=%b rw=%b mw=%b exp ce=%b", i, Cond, mflags, CondEx, PCWrite, RegWrite, MemWrite, ce); end
      step();
      n_cmp++; if (Flags !== mflags) begin n_err++; $display("FAIL random_flags i=%0d got=%b exp=%b", i, Flags, mflags); end
`ifdef COND_PERF_EN
      n_cmp++; if (InstrCount !== CW'(mi) || SquashCount !== CW'(ms)) begin
        n_err++; $display("FAIL random_counters i=%0d got=%0d/%0d exp=%0d/%0d", i, InstrCount, SquashCount, mi, ms); end
`endif
    end
    reset = 1;
    idle();
  endtask

`ifdef COND_PERF_EN
  task automatic test_perf();
    idle(); reset = 0; step(); reset = 1;
    NextPC = 1; step(); idle();
    RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0100; step(); idle();
    NextPC = 1; step(); idle();
    Cond = 4'b0001; RegW = 1; step(); idle();
    NextPC = 1; step(); idle();
    n_cmp++; if (InstrCount !== CW'(2) || SquashCount !== CW'(1)) begin
      n_err++; $display("FAIL perf_count got=%0d/%0d exp=2/1", InstrCount, SquashCount); end
    for (int i = 0; i < CMAX + 2; i++) begin
      Cond = 4'b0001; RegW = 1; step(); idle();
      NextPC = 1; step(); idle();
    end
    n_cmp++; if (InstrCount !== '1 || SquashCount !== '1) begin
      n_err++; $display("FAIL perf_saturate got=%0d/%0d exp=%0d/%0d", InstrCount, SquashCount, CMAX, CMAX); end
    Cond = 4'b0001; MemW = 1; step(); idle();
    NextPC = 1; step(); idle();
    n_cmp++; if (InstrCount !== '1 || SquashCount !== '1) begin
      n_err++; $display("FAIL perf_hold got=%0d/%0d exp=%0d/%0d", InstrCount, SquashCount, CMAX, CMAX); end
  endtask
`endif

  initial begin
    test_reset();
    test_cond_table();
    test_partial_flags();
    test_squashed_flag_write();
    test_branch_gating();
    test_random();
`ifdef COND_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
